// File: rtl/sdp_ram_ar.sv
// ---------------------------------------------------------------------------
// sdp_ram_ar
// Simple dual-port RAM: one synchronous write port and one asynchronous
// (combinational) read port, both in a single clock domain. Intended as the
// storage array under a FIFO, so that the head word is visible in the same
// cycle the FIFO raises its valid flag.
//
// Ports:
//   clk        - rising-edge clock for the write port
//   rst        - asynchronous active-high reset; clears every entry to 0
//   write      - write enable, sampled at the rising edge of clk
//   write_data - word to store
//   write_addr - write location
//   read_addr  - read location
//   read_data  - mem[read_addr], combinational (0 for out-of-range addresses)
// ---------------------------------------------------------------------------
module sdp_ram_ar #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int ADDR_W     = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_W-1:0]     write_addr,
  input  logic [ADDR_W-1:0]     read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  // Storage array; every entry is cleared by reset, so no X ever reaches
  // the read port.
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic w_wr_in_range;
  logic w_rd_in_range;

  // Address range qualification. With a non-power-of-2 depth some address
  // codes have no backing entry: writes there are dropped, reads return 0.
  always_comb begin
    w_wr_in_range = 1'b0;
    w_rd_in_range = 1'b0;
    if (int'(write_addr) < MEM_DEPTH) begin
      w_wr_in_range = 1'b1;
    end else begin
      w_wr_in_range = 1'b0;
    end
    if (int'(read_addr) < MEM_DEPTH) begin
      w_rd_in_range = 1'b1;
    end else begin
      w_rd_in_range = 1'b0;
    end
  end

  // Write port with asynchronous clear of the whole array. Reset has
  // priority, so a write attempted while rst is high is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (write && w_wr_in_range) begin
        r_mem[write_addr] <= write_data;
      end
    end
  end

  // Combinational read. There is deliberately no write-to-read bypass: on a
  // same-address collision the old word is shown until the clock edge.
  always_comb begin
    read_data = {DATA_WIDTH{1'b0}};
    if (w_rd_in_range) begin
      read_data = r_mem[read_addr];
    end else begin
      read_data = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_sdp_ram_ar.sv
// ---------------------------------------------------------------------------
// tb_sdp_ram_ar
// Self-checking bench for sdp_ram_ar. A plain array in the bench stands in
// for the memory; directed scenarios are followed by randomized traffic, and
// every observation of read_data is compared against that array.
// ---------------------------------------------------------------------------
module tb_sdp_ram_ar;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          write;
  logic [DW-1:0] write_data;
  logic [AW-1:0] write_addr;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;

  // Reference contents of the memory.
  logic [DW-1:0] model [DEPTH];

  int checks = 0;
  int errors = 0;

  sdp_ram_ar #(
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .write     (write),
    .write_data(write_data),
    .write_addr(write_addr),
    .read_addr (read_addr),
    .read_data (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Single write cycle: drive on the falling edge, commit on the rising edge.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    write      = 1'b1;
    write_addr = a;
    write_data = d;
    @(posedge clk);
    #1;
    write = 1'b0;
    if (!rst && int'(a) < DEPTH) model[a] = d;
  endtask

  // Sweep every address against the model.
  task automatic sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      read_addr = AW'(i);
      #1;
      check(tag, read_data, model[i]);
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          we;

    rst        = 1'b0;
    write      = 1'b0;
    write_data = '0;
    write_addr = '0;
    read_addr  = '0;
    clear_model();

    // Reset: the array must read all zeros, both during and after reset.
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    sweep("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    sweep("reset_after");

    // Write 0xA5 to address 3; address 4 must remain 0.
    do_write(AW'(3), 8'hA5);
    read_addr = AW'(3);
    #1 check("wr_rd_3", read_data, 8'hA5);
    read_addr = AW'(4);
    #1 check("addr4_zero", read_data, 8'h00);

    // Write enable low: nothing changes over several edges.
    @(negedge clk);
    write      = 1'b0;
    write_addr = AW'(3);
    write_data = 8'hFF;
    read_addr  = AW'(3);
    repeat (4) @(posedge clk);
    #1 check("we_low", read_data, 8'hA5);

    // Collision: old word until the edge, new word right after.
    do_write(AW'(5), 8'h11);
    @(negedge clk);
    read_addr  = AW'(5);
    write      = 1'b1;
    write_addr = AW'(5);
    write_data = 8'h22;
    #1 check("coll_pre", read_data, 8'h11);
    @(posedge clk);
    #1 check("coll_post", read_data, 8'h22);
    write = 1'b0;
    model[5] = 8'h22;

    // Full sweep: pattern addr ^ 0x5A, read back twice with address wrap.
    for (int i = 0; i < DEPTH; i++) begin
      do_write(AW'(i), DW'(i) ^ 8'h5A);
    end
    read_addr = AW'(DEPTH - 1);
    for (int k = 0; k < 2 * DEPTH; k++) begin
      read_addr = read_addr + 1'b1;
      #1 check("wrap_rd", read_data, DW'((k % DEPTH)) ^ 8'h5A);
    end

    // Randomized traffic with simultaneous read and write.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we         = 1'($urandom_range(0, 1));
      a          = AW'($urandom_range(0, DEPTH - 1));
      d          = DW'($urandom);
      write      = we;
      write_addr = a;
      write_data = d;
      read_addr  = (($urandom_range(0, 3)) == 0) ? a : AW'($urandom_range(0, DEPTH - 1));
      #1 check("rnd_pre", read_data, model[read_addr]);
      @(posedge clk);
      if (we) model[a] = d;
      #1 check("rnd_post", read_data, model[read_addr]);
    end
    @(negedge clk);
    write = 1'b0;

    // Mid-operation reset pulsed between edges: contents vanish at once,
    // and a write attempted during reset has no effect.
    sweep("pre_midrst");
    #2 rst = 1'b1;
    clear_model();
    #1;
    sweep("midrst_imm");
    @(negedge clk);
    write      = 1'b1;
    write_addr = AW'(7);
    write_data = 8'h77;
    read_addr  = AW'(7);
    @(posedge clk);
    #1 check("wr_in_rst", read_data, 8'h00);
    write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sweep("midrst_after");

    // Normal operation resumes after reset.
    do_write(AW'(9), 8'h3C);
    read_addr = AW'(9);
    #1 check("post_rst_wr", read_data, 8'h3C);
    read_addr = AW'(7);
    #1 check("post_rst_7", read_data, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
